// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, TX state encoding and a frame builder.
package uart_pkg;

  localparam int unsigned FRAME_W   = 10;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] data);
    return {STOP_BIT, data, START_BIT};
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: free-runs while clr is low and pulses tick on the last cycle of each bit.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Pops pre-formatted 10-bit UART frames over ready/valid and shifts them out LSB first on txd.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned GAP_BITS     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ivalid,
  output logic               iready,
  input  logic [FRAME_W-1:0] idata,
  output logic               txd,
  output logic               busy,
  output logic               frame_err
);

  localparam int unsigned GapW    = $clog2(15 * CLKS_PER_BIT);
  localparam int unsigned GapLast = (GAP_BITS > 0) ? GAP_BITS * CLKS_PER_BIT - 1 : 0;

  tx_state_t          state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic               frame_err_q, frame_err_d;
  logic               bit_tick;
  logic               accept;
  logic               frame_ok;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q != SHIFT),
    .tick (bit_tick)
  );

  assign iready    = (state_q == IDLE) && !reset;
  assign accept    = ivalid && iready;
  assign frame_ok  = (idata[0] == START_BIT) && (idata[FRAME_W-1] == STOP_BIT);
  // The shift register idles at all ones, so its LSB doubles as the registered line.
  assign txd       = shreg_q[0];
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    gap_cnt_d   = gap_cnt_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (frame_ok) begin
            shreg_d   = idata;
            bit_idx_d = '0;
            state_d   = SHIFT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          shreg_d = {1'b1, shreg_q[FRAME_W-1:1]};
          if (bit_idx_q == 4'(FRAME_W - 1)) begin
            bit_idx_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_BITS > 0) ? GAP : IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GapW'(GapLast)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '1;
      bit_idx_q   <= '0;
      gap_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: instance 0 without gap, instance 1 with a two-bit gap, both at 4 clk/bit.
module tb_uart_frame_tx;
  import uart_pkg::*;

  localparam int C = 4;

  logic       clk;
  logic [1:0] rst, ivalid, iready, txd, busy, ferr;
  logic [9:0] idata [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit checking = 0;

  // Line model: a pending waveform of per-cycle txd values; empty means idle.
  logic [63:0] m_wave [2];
  int          m_len  [2];
  logic        m_err  [2];

  uart_frame_tx #(.CLKS_PER_BIT(C), .GAP_BITS(0)) dut0 (
    .clk(clk), .reset(rst[0]), .ivalid(ivalid[0]), .iready(iready[0]), .idata(idata[0]),
    .txd(txd[0]), .busy(busy[0]), .frame_err(ferr[0])
  );

  uart_frame_tx #(.CLKS_PER_BIT(C), .GAP_BITS(2)) dut1 (
    .clk(clk), .reset(rst[1]), .ivalid(ivalid[1]), .iready(iready[1]), .idata(idata[1]),
    .txd(txd[1]), .busy(busy[1]), .frame_err(ferr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic logic [63:0] w = m_wave[k];
      automatic int          n = m_len[k];
      automatic logic        e = 1'b0;
      if (rst[k]) begin
        n = 0;
      end else if (n > 0) begin
        w = w >> 1;
        n--;
      end else if (ivalid[k]) begin
        if (idata[k][0] == 1'b0 && idata[k][9] == 1'b1) begin
          w = '1;
          for (int b = 0; b < 10; b++)
            for (int c = 0; c < C; c++) w[b*C+c] = idata[k][b];
          n = 10 * C + gap_of(k) * C;
        end else begin
          e = 1'b1;
        end
      end
      m_wave[k] <= w;
      m_len[k]  <= n;
      m_err[k]  <= e;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("txd%0d", k), 64'(txd[k]), (m_len[k] > 0) ? 64'(m_wave[k][0]) : 64'd1);
        chk($sformatf("busy%0d", k), 64'(busy[k]), 64'(m_len[k] > 0));
        chk($sformatf("iready%0d", k), 64'(iready[k]), 64'(m_len[k] == 0 && !rst[k]));
        chk($sformatf("frame_err%0d", k), 64'(ferr[k]), 64'(m_err[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after the accepting edge; samples the middle of each bit.
  task automatic capture_frame(input int k, output logic [9:0] bits);
    for (int b = 0; b < 10; b++) begin
      tick();
      bits[b] = txd[k];
      repeat (3) tick();
    end
  endtask

  task automatic wait_ready(input int k, output int busy_cnt);
    automatic int waited = 0;
    busy_cnt = 0;
    while (iready[k] !== 1'b1 && waited < 200) begin
      if (busy[k] === 1'b1) busy_cnt++;
      tick();
      waited++;
    end
    if (iready[k] !== 1'b1) chk("ready_timeout", 64'(iready[k]), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  f;
    logic [39:0] line;
    logic [9:0]  fr;
    int          nb, t_a, t_b, bc;

    rst = 2'b11; ivalid = 2'b01; idata[0] = 10'h2AA; idata[1] = 10'h2AA;
    tick();
    checking = 1;
    chk("reset_iready", 64'(iready[0]), 64'd0);
    chk("reset_txd", 64'(txd[0]), 64'd1);
    tick(); tick();
    rst = 2'b00; ivalid = 2'b00;
    #1;
    chk("iready_after_release", 64'(iready[0]), 64'd1);
    tick();
    chk("no_transfer_busy", 64'(busy[0]), 64'd0);

    // Single frame 0x55.
    fr = make_frame(8'h55);
    chk("make_frame_55", 64'(fr), 64'h2AA);
    idata[0] = fr; ivalid[0] = 1'b1;
    tick();
    ivalid[0] = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      line[i] = txd[0];
      if (busy[0]) nb++;
      tick();
    end
    chk("frame55_line", 64'(line), 64'hF0F0F0F0F0);
    chk("frame55_busy_cycles", 64'(nb), 64'd40);
    chk("frame55_ready_at_41", 64'(iready[0]), 64'd1);

    // Back-to-back with the FIFO holding ivalid.
    idata[0] = 10'h200; ivalid[0] = 1'b1;
    wait_ready(0, bc);
    t_a = cyc;
    tick();
    idata[0] = 10'h3FE;
    capture_frame(0, f);
    chk("b2b_frame00", 64'(f), 64'h200);
    wait_ready(0, bc);
    t_b = cyc;
    chk("b2b_spacing", 64'(t_b - t_a), 64'd41);
    tick();
    ivalid[0] = 1'b0;
    capture_frame(0, f);
    chk("b2b_frameFF", 64'(f), 64'h3FE);

    // Framing error then immediate valid frame.
    idata[0] = 10'h2AB; ivalid[0] = 1'b1;
    wait_ready(0, bc);
    tick();
    chk("ferr_pulse", 64'(ferr[0]), 64'd1);
    chk("ferr_txd", 64'(txd[0]), 64'd1);
    chk("ferr_iready", 64'(iready[0]), 64'd1);
    idata[0] = 10'h2AA;
    tick();
    ivalid[0] = 1'b0;
    chk("ferr_cleared", 64'(ferr[0]), 64'd0);
    chk("after_err_start", 64'(txd[0]), 64'd0);
    capture_frame(0, f);
    chk("after_err_frame", 64'(f), 64'h2AA);

    // Reset during bit 4.
    ivalid[0] = 1'b1;
    wait_ready(0, bc);
    tick();
    ivalid[0] = 1'b0;
    repeat (17) tick();
    chk("mid_bit4", 64'(txd[0]), 64'd0);
    rst[0] = 1'b1;
    tick();
    chk("abort_txd", 64'(txd[0]), 64'd1);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_iready", 64'(iready[0]), 64'd0);
    rst[0] = 1'b0;
    ivalid[0] = 1'b1;
    wait_ready(0, bc);
    tick();
    ivalid[0] = 1'b0;
    capture_frame(0, f);
    chk("post_abort_frame", 64'(f), 64'h2AA);

    // Two-bit gap instance, back-to-back.
    idata[1] = 10'h2AA; ivalid[1] = 1'b1;
    wait_ready(1, bc);
    t_a = cyc;
    tick();
    capture_frame(1, f);
    chk("gap_frame1", 64'(f), 64'h2AA);
    wait_ready(1, bc);
    t_b = cyc;
    chk("gap_busy_cycles", 64'(bc), 64'd8);
    chk("gap_spacing", 64'(t_b - t_a), 64'd49);
    tick();
    ivalid[1] = 1'b0;
    capture_frame(1, f);
    chk("gap_frame2", 64'(f), 64'h2AA);
    wait_ready(1, bc);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
